// File: rtl/seven_seg_if.sv
// seven_seg_if: digit/mask inputs and scanned display outputs of the seven-segment scanner.
interface seven_seg_if;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic        dp_n;
    logic        frame_start;
    modport master (output enable, digits, blink_mask, dp_mask, input nib, an, dp_n, frame_start);
    modport slave (input enable, digits, blink_mask, dp_mask, output nib, an, dp_n, frame_start);
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed four-digit common-anode driver with blanking gap and blink mask.
module seven_seg_scanner #(
    parameter int DIV       = 50000,
    parameter int BLANK     = 500,
    parameter int BLINK_DIV = 60
) (
    input logic clk,
    input logic rst,
    seven_seg_if.slave bus
);
    localparam int CMAX = DIV > BLANK ? DIV : BLANK;
    localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
    localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] B_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DIV - 1);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_DIV - 1);
    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0] idx, idx_d;
    logic [15:0] snap, snap_d;
    logic [FW-1:0] fcnt, fcnt_d;
    logic phase, phase_d;
    logic [3:0] nib, nib_d, an, an_d;
    logic dp_n, dp_n_d, fs, fs_d;
    logic [1:0] nxt_idx;
    logic hide;
    assign nxt_idx = idx + 2'd1;
    assign hide = !phase && bus.blink_mask[idx];
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        idx_d = idx;
        snap_d = snap;
        fcnt_d = fcnt;
        phase_d = phase;
        nib_d = nib;
        an_d = an;
        dp_n_d = dp_n;
        fs_d = 1'b0;
        if (!bus.enable) begin
            state_d = S_IDLE;
            cnt_d = '0;
            idx_d = 2'd0;
            fcnt_d = '0;
            phase_d = 1'b1;
            an_d = 4'hF;
            dp_n_d = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d = '0;
                    idx_d = 2'd0;
                    snap_d = bus.digits;
                    nib_d = bus.digits[3:0];
                    fs_d = 1'b1;
                end
                S_BLANK: begin
                    cnt_d = cnt == B_LAST ? '0 : cnt + 1'b1;
                    if (cnt == B_LAST) begin
                        state_d = S_DRIVE;
                        an_d = hide ? 4'hF : ~(4'b0001 << idx);
                        dp_n_d = hide | ~bus.dp_mask[idx];
                    end
                end
                S_DRIVE: begin
                    cnt_d = cnt == D_LAST ? '0 : cnt + 1'b1;
                    if (cnt == D_LAST) begin
                        state_d = S_BLANK;
                        idx_d = nxt_idx;
                        an_d = 4'hF;
                        dp_n_d = 1'b1;
                        nib_d = snap[{nxt_idx, 2'b00} +: 4];
                        // Wrapping re-snapshots so each frame shows one coherent value.
                        if (idx == 2'd3) begin
                            snap_d = bus.digits;
                            nib_d = bus.digits[3:0];
                            fs_d = 1'b1;
                            fcnt_d = fcnt == F_LAST ? '0 : fcnt + 1'b1;
                            phase_d = fcnt == F_LAST ? ~phase : phase;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt <= '0;
            idx <= 2'd0;
            snap <= 16'h0;
            fcnt <= '0;
            phase <= 1'b1;
            nib <= 4'h0;
            an <= 4'hF;
            dp_n <= 1'b1;
            fs <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            idx <= idx_d;
            snap <= snap_d;
            fcnt <= fcnt_d;
            phase <= phase_d;
            nib <= nib_d;
            an <= an_d;
            dp_n <= dp_n_d;
            fs <= fs_d;
        end
    end
    assign bus.nib = nib;
    assign bus.an = an;
    assign bus.dp_n = dp_n;
    assign bus.frame_start = fs;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed and random scan checks against a frame-position reference model.
module tb_seven_seg_scanner;
    localparam int DIV = 4;
    localparam int BLANK = 2;
    localparam int BLINK_DIV = 2;
    localparam int SLOT = BLANK + DIV;
    localparam int FRAME = 4 * SLOT;
    logic clk = 1'b0;
    logic rst, rst2;
    int n_checks = 0;
    int n_fail = 0;
    seven_seg_if bus ();
    seven_seg_if mb ();
    seven_seg_scanner #(.DIV(DIV), .BLANK(BLANK), .BLINK_DIV(BLINK_DIV)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    seven_seg_scanner #(.DIV(1), .BLANK(1), .BLINK_DIV(2)) dut_min (.clk(clk), .rst(rst2), .bus(mb.slave));
    always #5 clk = ~clk;
    // Model state: position counted in cycles since the frame sequence started.
    bit run = 0;
    int t = 0;
    int m_p = 0;
    logic [15:0] m_snap = 16'h0;
    logic [3:0] m_nib = 4'h0, m_an = 4'hF;
    logic m_dp = 1'b1, m_fs = 1'b0;
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic model_edge();
        int slot, off;
        bit hide;
        if (rst) begin
            run = 0; m_snap = 16'h0; m_nib = 4'h0; m_an = 4'hF; m_dp = 1'b1; m_fs = 1'b0;
        end else if (!bus.enable) begin
            run = 0; m_an = 4'hF; m_dp = 1'b1; m_fs = 1'b0;
        end else begin
            t = run ? t + 1 : 0;
            run = 1;
            m_p = t % FRAME;
            slot = m_p / SLOT;
            off = m_p % SLOT;
            if (m_p == 0) m_snap = bus.digits;
            m_fs = (m_p == 0);
            m_nib = m_snap[slot*4 +: 4];
            if (off == BLANK) begin
                hide = (((t / FRAME) / BLINK_DIV) % 2 == 1) && bus.blink_mask[slot];
                m_an = hide ? 4'hF : ~(4'b0001 << slot);
                m_dp = hide | ~bus.dp_mask[slot];
            end else if (off < BLANK) begin
                m_an = 4'hF;
                m_dp = 1'b1;
            end
        end
    endtask
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("an", 16'(bus.an), 16'(m_an));
        check("dp_n", 16'(bus.dp_n), 16'(m_dp));
        check("nib", 16'(bus.nib), 16'(m_nib));
        check("frame_start", 16'(bus.frame_start), 16'(m_fs));
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    task automatic run_to(input int s, input int o);
        int n = 0;
        while (m_p != s * SLOT + o && n < 100) begin
            tick();
            n++;
        end
        check("run_to_timeout", 16'(n < 100), 16'd1);
    endtask
    logic [3:0] tbl [8];
    initial begin
        tbl[0] = 4'hF; tbl[1] = 4'hE; tbl[2] = 4'hF; tbl[3] = 4'hD;
        tbl[4] = 4'hF; tbl[5] = 4'hB; tbl[6] = 4'hF; tbl[7] = 4'h7;
        rst = 1'b1; rst2 = 1'b1;
        bus.enable = 1'b0; bus.digits = 16'h0; bus.blink_mask = 4'h0; bus.dp_mask = 4'h0;
        mb.enable = 1'b0; mb.digits = 16'h0; mb.blink_mask = 4'h0; mb.dp_mask = 4'h0;
        ticks(3);
        check("reset_an", 16'(bus.an), 16'hF);
        check("reset_nib", 16'(bus.nib), 16'h0);
        rst = 1'b0; bus.enable = 1'b1; bus.digits = 16'h1234;
        tick();
        check("start_fs", 16'(bus.frame_start), 16'd1);
        check("start_nib", 16'(bus.nib), 16'h4);
        ticks(2);
        check("start_an0", 16'(bus.an), 16'hE);
        ticks(2 * FRAME - 3);
        run_to(1, BLANK + 1);
        bus.digits = 16'h5678;
        run_to(2, 0);
        check("snap_d2", 16'(bus.nib), 16'h2);
        run_to(3, 0);
        check("snap_d3", 16'(bus.nib), 16'h1);
        run_to(0, 0);
        check("snap_new_fs", 16'(bus.frame_start), 16'd1);
        check("snap_new_nib", 16'(bus.nib), 16'h8);
        run_to(2, BLANK + 1);
        bus.enable = 1'b0;
        tick();
        check("drop_an", 16'(bus.an), 16'hF);
        check("drop_dp", 16'(bus.dp_n), 16'd1);
        ticks(4);
        bus.blink_mask = 4'b0011; bus.dp_mask = 4'b0100; bus.enable = 1'b1;
        tick();
        check("reen_fs", 16'(bus.frame_start), 16'd1);
        ticks(4 * FRAME - 1);
        run_to(3, 0);
        rst = 1'b1;
        tick();
        check("mid_rst_nib", 16'(bus.nib), 16'h0);
        rst = 1'b0; bus.digits = 16'h1234; bus.blink_mask = 4'h0; bus.dp_mask = 4'h0;
        ticks(FRAME);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 12) bus.digits = 16'($urandom);
            if (r < 4) begin
                bus.blink_mask = 4'($urandom);
                bus.dp_mask = 4'($urandom);
            end
            if (r == 50) bus.enable = 1'b0;
            else if (r >= 95) bus.enable = 1'b1;
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; bus.enable = 1'b1;
        rst2 = 1'b0; mb.enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("min_an", 16'(mb.an), 16'(tbl[i % 8]));
            check("min_fs", 16'(mb.frame_start), 16'(i % 8 == 0));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
